// File: rtl/plcp_receiver.sv
`default_nettype none
// ============================================================================
// Module  : plcp_receiver
// Brief   : 802.11 PLCP receive deframer. It hunts the preamble, checks the
//           SIGNAL field, descrambles DATA and emits the PSDU bits.
//           Optional: PLCP_RX_SEED_RECOVERY_EN recovers the descrambler state
//           from the first 7 SERVICE bits.
// Revision: 1.0 - initial release
// ============================================================================
module plcp_receiver #(
  parameter int         PREAMBLE_LEN   = 96,
  parameter int         N_DBPS         = 24,
  parameter int         SERVICE_LEN    = 16,
  parameter int         TAIL_LEN       = 6,
  parameter logic [6:0] SCRAMBLER_SEED = 7'h7F
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Input,
  input  logic        InValid,
  output logic        Output,
  output logic        OutValid,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic        SignalValid,
  output logic        SignalErr,
  output logic        FrameDone,
  output logic        Busy
);

  localparam int c_RUN_W = $clog2(PREAMBLE_LEN + 1);
  localparam int c_SYM_W = $clog2(N_DBPS + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX      = c_RUN_W'(PREAMBLE_LEN);
  localparam logic [c_SYM_W-1:0] c_SYM_LAST     = c_SYM_W'(N_DBPS - 1);
  localparam logic [14:0]        c_SERVICE_LAST = 15'(SERVICE_LEN - 1);
  localparam logic [14:0]        c_TAIL_LAST    = 15'(TAIL_LEN - 1);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_SIGNAL  = 3'd1,
    ST_SERVICE = 3'd2,
    ST_PSDU    = 3'd3,
    ST_TAIL    = 3'd4,
    ST_PAD     = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_prev_bit;
  logic [c_RUN_W-1:0]   r_run;
  logic [14:0]          r_bit_cnt;
  logic [c_SYM_W-1:0]   r_sym_cnt;
  logic [6:0]           r_scr;
  logic                 r_parity;
  logic                 r_reserved;
  logic                 r_tail_err;
  logic [3:0]           r_rate_sh;
  logic [11:0]          r_len_sh;

  logic [c_RUN_W-1:0]   w_run_next;
  logic                 w_lock;
  logic                 w_fb;
  logic                 w_data;
  logic [c_SYM_W-1:0]   w_sym_next;
  logic [14:0]          w_bit_next;
  logic [14:0]          w_psdu_bits;
  logic                 w_sig_err;
  logic                 w_in_data;

  assign w_run_next  = (Input == r_prev_bit) ? '0 :
                       (r_run == c_RUN_MAX)  ? r_run : r_run + 1'b1;
  assign w_lock      = (w_run_next == c_RUN_MAX) && !Input;
  assign w_fb        = r_scr[6] ^ r_scr[3];
  assign w_data      = Input ^ w_fb;
  assign w_sym_next  = (r_sym_cnt == c_SYM_LAST) ? '0 : r_sym_cnt + 1'b1;
  assign w_bit_next  = r_bit_cnt + 15'd1;
  assign w_psdu_bits = {Length, 3'b000};
  assign w_in_data   = (r_state != ST_HUNT) && (r_state != ST_SIGNAL);
  // Evaluated on SIGNAL bit 23, so the current input is the last tail bit.
  assign w_sig_err   = r_parity | r_reserved | r_tail_err | Input | (r_len_sh == 12'd0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= ST_HUNT;
      r_prev_bit  <= 1'b0;
      r_run       <= '0;
      r_bit_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_scr       <= SCRAMBLER_SEED;
      r_parity    <= 1'b0;
      r_reserved  <= 1'b0;
      r_tail_err  <= 1'b0;
      r_rate_sh   <= '0;
      r_len_sh    <= '0;
      Output      <= 1'b0;
      OutValid    <= 1'b0;
      Rate        <= '0;
      Length      <= '0;
      SignalValid <= 1'b0;
      SignalErr   <= 1'b0;
      FrameDone   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      OutValid    <= 1'b0;
      SignalValid <= 1'b0;
      SignalErr   <= 1'b0;
      FrameDone   <= 1'b0;
      if (InValid) begin
        if (w_in_data) begin
          r_scr     <= {r_scr[5:0], w_fb};
          r_sym_cnt <= w_sym_next;
          r_bit_cnt <= w_bit_next;
        end
        case (r_state)
          ST_HUNT: begin
            r_prev_bit <= Input;
            r_run      <= w_run_next;
            if (w_lock) begin
              r_state    <= ST_SIGNAL;
              r_bit_cnt  <= '0;
              r_parity   <= 1'b0;
              r_reserved <= 1'b0;
              r_tail_err <= 1'b0;
              Busy       <= 1'b1;
            end
          end
          ST_SIGNAL: begin
            r_bit_cnt <= w_bit_next;
            if (r_bit_cnt <= 15'd17) r_parity <= r_parity ^ Input;
            if (r_bit_cnt <= 15'd3) r_rate_sh <= {r_rate_sh[2:0], Input};
            if (r_bit_cnt == 15'd4) r_reserved <= Input;
            if (r_bit_cnt >= 15'd5 && r_bit_cnt <= 15'd16) r_len_sh <= {r_len_sh[10:0], Input};
            if (r_bit_cnt >= 15'd18) r_tail_err <= r_tail_err | Input;
            if (r_bit_cnt == 15'd23) begin
              Rate      <= r_rate_sh;
              Length    <= r_len_sh;
              r_bit_cnt <= '0;
              if (w_sig_err) begin
                SignalErr <= 1'b1;
                r_state   <= ST_HUNT;
                r_run     <= '0;
                Busy      <= 1'b0;
              end else begin
                SignalValid <= 1'b1;
                r_scr       <= SCRAMBLER_SEED;
                r_sym_cnt   <= '0;
                r_state     <= ST_SERVICE;
              end
            end
          end
          ST_SERVICE: begin
`ifdef PLCP_RX_SEED_RECOVERY_EN
            // Scrambled zeros are the transmitter feedback bits themselves.
            if (r_bit_cnt < 15'd7) r_scr <= {r_scr[5:0], Input};
`endif
            if (r_bit_cnt == c_SERVICE_LAST) begin
              r_state   <= ST_PSDU;
              r_bit_cnt <= '0;
            end
          end
          ST_PSDU: begin
            Output   <= w_data;
            OutValid <= 1'b1;
            if (w_bit_next == w_psdu_bits) begin
              r_state   <= ST_TAIL;
              r_bit_cnt <= '0;
            end
          end
          ST_TAIL: begin
            if (r_bit_cnt == c_TAIL_LAST) begin
              r_bit_cnt <= '0;
              if (w_sym_next == '0) begin
                FrameDone  <= 1'b1;
                r_state    <= ST_HUNT;
                r_run      <= '0;
                r_prev_bit <= 1'b0;
                Busy       <= 1'b0;
              end else begin
                r_state <= ST_PAD;
              end
            end
          end
          ST_PAD: begin
            if (w_sym_next == '0) begin
              FrameDone  <= 1'b1;
              r_state    <= ST_HUNT;
              r_run      <= '0;
              r_prev_bit <= 1'b0;
              r_bit_cnt  <= '0;
              Busy       <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_HUNT;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plcp_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_plcp_receiver
// Brief   : Self-checking bench for plcp_receiver (frame table plus reset case).
// Revision: 1.0 - initial release
// ============================================================================
module tb_plcp_receiver;

`ifdef PLCP_RX_SEED_RECOVERY_EN
  localparam int c_RECOVER = 1;
`else
  localparam int c_RECOVER = 0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Input = 1'b0;
  logic        InValid = 1'b0;
  logic        Output;
  logic        OutValid;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic        SignalValid;
  logic        SignalErr;
  logic        FrameDone;
  logic        Busy;

  plcp_receiver dut (
    .Clock(Clock), .Reset(Reset), .Input(Input), .InValid(InValid),
    .Output(Output), .OutValid(OutValid), .Rate(Rate), .Length(Length),
    .SignalValid(SignalValid), .SignalErr(SignalErr), .FrameDone(FrameDone),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string      name;
    int         idle;
    int         pre_len;
    logic [3:0] rate;
    int         len;
    logic [6:0] seed;
    int         err_kind;     // 0 none, 1 parity, 2 reserved, 3 tail
    int         rand_payload;
    int         stall_pct;
    int         exp_sv;
    int         exp_se;
    int         exp_fd;
    int         exp_match;
  } vec_t;

  vec_t vecs[$];
  logic frame_q[$];
  logic exp_bits[$];
  logic rx_q[$];
  int   sv_cnt = 0, se_cnt = 0, fd_cnt = 0, busy_cnt = 0;
  int   checks = 0, errors = 0;

  always @(negedge Clock) begin
    if (SignalValid) sv_cnt++;
    if (SignalErr) se_cnt++;
    if (FrameDone) fd_cnt++;
    if (Busy) busy_cnt++;
    if (OutValid) rx_q.push_back(Output);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int idle, input int pre_len,
                              input logic [3:0] rate, input int len, input logic [6:0] seed,
                              input int err_kind, input int rnd, input int stall,
                              input int sv, input int se, input int fd, input int match);
    vec_t v;
    v.name = name; v.idle = idle; v.pre_len = pre_len; v.rate = rate; v.len = len;
    v.seed = seed; v.err_kind = err_kind; v.rand_payload = rnd; v.stall_pct = stall;
    v.exp_sv = sv; v.exp_se = se; v.exp_fd = fd; v.exp_match = match;
    return v;
  endfunction

  // Transmitter model: preamble, SIGNAL with even parity, scrambled DATA.
  task automatic build(input vec_t v);
    logic [6:0]  s;
    logic        fb;
    logic        par;
    logic [7:0]  byte_v;
    logic [11:0] len12;
    logic        raw[$];
    frame_q.delete();
    exp_bits.delete();
    repeat (v.idle) frame_q.push_back(1'b0);
    for (int i = 0; i < v.pre_len; i++) frame_q.push_back((i % 2) == 0);
    par = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      frame_q.push_back(v.rate[i]);
      par ^= v.rate[i];
    end
    frame_q.push_back(v.err_kind == 2);
    par ^= (v.err_kind == 2);
    len12 = 12'(v.len);
    for (int i = 11; i >= 0; i--) begin
      frame_q.push_back(len12[i]);
      par ^= len12[i];
    end
    frame_q.push_back(par ^ (v.err_kind == 1));
    for (int i = 0; i < 6; i++) frame_q.push_back((v.err_kind == 3) && (i == 2));
    repeat (16) raw.push_back(1'b0);
    for (int k = 0; k < v.len; k++) begin
      byte_v = (v.rand_payload != 0) ? 8'($urandom) : 8'hA5;
      for (int j = 0; j < 8; j++) begin
        raw.push_back(byte_v[j]);
        exp_bits.push_back(byte_v[j]);
      end
    end
    repeat (6) raw.push_back(1'b0);
    while ((raw.size() % 24) != 0) raw.push_back(1'b0);
    s = v.seed;
    foreach (raw[i]) begin
      fb = s[6] ^ s[3];
      frame_q.push_back(raw[i] ^ fb);
      s = {s[5:0], fb};
    end
  endtask

  task automatic send_bit(input logic b, input int stall_pct);
    while (int'($urandom_range(99)) < stall_pct) begin
      InValid = 1'b0;
      Input   = 1'($urandom_range(1));
      @(posedge Clock); #1;
    end
    Input   = b;
    InValid = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int sv0, se0, fd0, rx0, busy0, nout, match;
    build(v);
    sv0 = sv_cnt; se0 = se_cnt; fd0 = fd_cnt; rx0 = rx_q.size(); busy0 = busy_cnt;
    foreach (frame_q[i]) send_bit(frame_q[i], v.stall_pct);
    InValid = 1'b0;
    @(negedge Clock);
    if (v.exp_fd != 0) begin
      chk({v.name, "/frame_done_timing"}, int'(FrameDone), 1);
      chk({v.name, "/busy_after_done"}, int'(Busy), 0);
    end
    @(posedge Clock); #1;
    chk({v.name, "/signal_valid"}, sv_cnt - sv0, v.exp_sv);
    chk({v.name, "/signal_err"}, se_cnt - se0, v.exp_se);
    chk({v.name, "/frame_done"}, fd_cnt - fd0, v.exp_fd);
    nout = rx_q.size() - rx0;
    chk({v.name, "/psdu_count"}, nout, (v.exp_sv != 0) ? 8 * v.len : 0);
    if (v.exp_sv == 0 && v.exp_se == 0) chk({v.name, "/busy_cycles"}, busy_cnt - busy0, 0);
    if (v.exp_sv != 0) begin
      match = (nout == exp_bits.size()) ? 1 : 0;
      for (int i = 0; i < nout && match != 0; i++)
        if (rx_q[rx0 + i] !== exp_bits[i]) match = 0;
      chk({v.name, "/psdu_match"}, match, v.exp_match);
      chk({v.name, "/rate"}, int'(Rate), int'(v.rate));
      chk({v.name, "/length"}, int'(Length), v.len);
    end
  endtask

  initial begin
    int n;
    //           name         idle pre rate   len   seed   err rnd stall sv se fd match
    vecs.push_back(mk("clean",      10, 96, 4'hD,   16, 7'h7F, 0, 0, 0,  1, 0, 1, 1));
    vecs.push_back(mk("parity_err", 10, 96, 4'hD,   16, 7'h7F, 1, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk("after_err",  10, 96, 4'hB,    5, 7'h7F, 0, 1, 0,  1, 0, 1, 1));
    vecs.push_back(mk("short_pre",  10, 94, 4'hD,   16, 7'h7F, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk("stall30",    10, 96, 4'hD,   16, 7'h7F, 0, 0, 30, 1, 0, 1, 1));
    vecs.push_back(mk("reserved",   10, 96, 4'h9,    3, 7'h7F, 2, 1, 0,  0, 1, 0, 1));
    vecs.push_back(mk("tail_err",   10, 96, 4'h9,    3, 7'h7F, 3, 1, 0,  0, 1, 0, 1));
    vecs.push_back(mk("len_zero",   10, 96, 4'hD,    0, 7'h7F, 0, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk("len_one",     4, 96, 4'hF,    1, 7'h7F, 0, 1, 20, 1, 0, 1, 1));
    vecs.push_back(mk("seed_5d",    10, 96, 4'hD,   16, 7'h5D, 0, 0, 0,  1, 0, 1, c_RECOVER));
    vecs.push_back(mk("len_max",    10, 96, 4'h8, 4095, 7'h7F, 0, 1, 0,  1, 0, 1, 1));

    Reset   = 1'b1;
    InValid = 1'b1;
    repeat (3) begin
      Input = 1'($urandom_range(1));
      @(posedge Clock); #1;
    end
    InValid = 1'b0;
    @(negedge Clock);
    chk("reset/out_valid", int'(OutValid), 0);
    chk("reset/busy", int'(Busy), 0);
    chk("reset/rate", int'(Rate), 0);
    chk("reset/length", int'(Length), 0);
    chk("reset/signal_valid", int'(SignalValid), 0);
    chk("reset/signal_err", int'(SignalErr), 0);
    chk("reset/frame_done", int'(FrameDone), 0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while PSDU bit 50 is on the input.
    build(vecs[0]);
    n = 10 + 96 + 24 + 16 + 50;
    for (int i = 0; i < n; i++) send_bit(frame_q[i], 0);
    chk("midreset/busy_before", int'(Busy), 1);
    Reset   = 1'b1;
    Input   = frame_q[n];
    InValid = 1'b1;
    @(posedge Clock); #1;
    Reset   = 1'b0;
    InValid = 1'b0;
    @(negedge Clock);
    chk("midreset/out_valid", int'(OutValid), 0);
    chk("midreset/busy", int'(Busy), 0);
    chk("midreset/rate", int'(Rate), 0);
    chk("midreset/length", int'(Length), 0);
    chk("midreset/signal_valid", int'(SignalValid), 0);
    @(posedge Clock); #1;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plcp_receiver.md
Name: plcp_receiver

Overview:
- Receive-side PLCP deframer for the 802.11 bit-serial chain.
- Takes the recovered, uncoded bit stream (after deinterleaving and decoding), hunts the alternating preamble, and parses and checks the SIGNAL field (RATE, reserved, LENGTH, parity, tail).
- Descrambles the DATA field and emits only the PSDU bits, discarding SERVICE, tail and pad bits.
- Sits between the decoder and the MAC-side byte assembler.

Parameters:
- PREAMBLE_LEN, 96, alternating preamble bits, first bit 1, last bit 0
- N_DBPS, 24, data bits per OFDM symbol; DATA field is padded to a multiple of this
- SERVICE_LEN, 16, SERVICE bits at the start of DATA
- TAIL_LEN, 6, DATA tail bits following the PSDU
- SCRAMBLER_SEED, 7'h7F, descrambler state loaded at the start of SERVICE

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high; clears all state
- Input  in  1  received serial bit
- InValid  in  1  Input is consumed only in cycles where this is high
- Output  out  1  descrambled PSDU bit
- OutValid  out  1  Output is valid this cycle
- Rate  out  4  RATE field, MSB = first received bit
- Length  out  12  LENGTH field in bytes, MSB first
- SignalValid  out  1  one-cycle pulse when SIGNAL passes all checks
- SignalErr  out  1  one-cycle pulse when SIGNAL fails a check
- FrameDone  out  1  one-cycle pulse after the last pad bit
- Busy  out  1  high in every state except HUNT

Behaviour:
- Interface: one clock (Clock); Reset is synchronous and active-high.
- Reset values: all outputs 0; state HUNT; prev_bit=0; run=0; all counters=0; descrambler=SCRAMBLER_SEED.
- Stall: a cycle with InValid low changes no state or counter. Pulse outputs and OutValid are 0 in that cycle.
- All outputs are registered. Each output appears one cycle after the bit that causes it is accepted.

HUNT:
- Per accepted bit b: if b==prev_bit then run<=0, else run<=run+1 (run saturates at PREAMBLE_LEN). prev_bit<=b.
- Two idle zeros followed by the preamble give run==PREAMBLE_LEN exactly on the final preamble 0.
- Lock when the updated run==PREAMBLE_LEN and b==0. On lock, go to SIGNAL and set the bit counter to 0.

SIGNAL (24 bits):
- Bits 0-3 shift into Rate; bit 4 is reserved; bits 5-16 shift into Length; bit 17 is parity; bits 18-23 are tail.
- A running XOR covers bits 0-17.
- After bit 23, the field is an error if any of these hold: XOR != 0, reserved == 1, any tail bit == 1, or Length == 0.
  - Error: pulse SignalErr, go to HUNT, clear run.
  - Otherwise: pulse SignalValid, load descrambler with SCRAMBLER_SEED, zero sym_cnt, go to SERVICE.
- Rate and Length hold their values until the next SIGNAL completes or Reset.

Descrambler (SERVICE, PSDU, TAIL, PAD):
- fb = s[6]^s[3]; d = b^fb; s <= {s[5:0], fb}.
- sym_cnt counts accepted DATA bits modulo N_DBPS.

Data states:
- SERVICE: SERVICE_LEN bits, descrambled and discarded.
- PSDU: Length*8 bits. Each bit drives Output=d, OutValid=1. The counter is 15-bit and compares against {Length,3'b000}.
- TAIL: TAIL_LEN bits, discarded.
- PAD: bits are discarded until sym_cnt wraps to 0. If sym_cnt is already 0 on entry, PAD takes zero bits.
- After the last DATA bit, pulse FrameDone, go to HUNT, run=0, prev_bit=0.

Boundary conditions:
- Length==4095 → 32760 PSDU bits with no counter overflow.
- A Reset asserted in any state wins over every other event in that cycle.
- A SignalErr does not drop bits: the bit after the failing SIGNAL field is processed in HUNT.

Optional Feature:
- Macro PLCP_RX_SEED_RECOVERY_EN.
- Defined:
  - The first 7 SERVICE bits are assumed to be scrambled zeros.
  - These raw bits shift into s (s <= {s[5:0], b}), replacing the SCRAMBLER_SEED load.
  - Descrambling proceeds from the recovered state, so any transmitter seed is tracked.
- Undefined: s is loaded with SCRAMBLER_SEED at SERVICE entry, as described above.

Test Plan:
- Clean frame: 10 zeros, 96-bit 1010..10 preamble, SIGNAL Rate=4'b1101, Length=12'h010 with correct parity, DATA scrambled from seed 7'h7F, 128 PSDU bits = 8'hA5 repeated → SignalValid pulse, 128 OutValid bits matching the pattern, DATA total 168 bits (7×24), FrameDone one cycle after the last pad bit.
- Parity error: same frame with parity bit inverted → SignalErr pulse, no OutValid; a following clean frame is received correctly.
- Short preamble: 94 alternating bits then SIGNAL → no lock, Busy stays 0, no pulses.
- Stall: drop InValid randomly on ~30% of cycles during the clean frame → identical OutValid bit sequence and Rate/Length.
- Reset mid-PSDU: assert Reset for 1 cycle at PSDU bit 50 → all outputs 0 next cycle, Busy=0; a subsequent clean frame passes.
- With PLCP_RX_SEED_RECOVERY_EN: transmit with seed 7'h5D, receiver SCRAMBLER_SEED=7'h7F → PSDU recovered error-free. Without the macro, the same stimulus gives a mismatched PSDU.
